// File: rtl/tdt_dtm_pkg.sv
// rtl/tdt_dtm_pkg.sv - shared TAP state encoding, IR codes and IDCODE default
package tdt_dtm_pkg;

    localparam int          DTM_IR_W       = 5;
    localparam logic [4:0]  DTM_IR_IDCODE  = 5'h01;
    localparam logic [4:0]  DTM_IR_DTMCS   = 5'h10;
    localparam logic [4:0]  DTM_IR_DMI     = 5'h11;
    localparam logic [31:0] DTM_IDCODE_VAL = 32'h1000_0B6D;

    typedef enum logic [3:0] {
        TLR    = 4'd0,
        RTI    = 4'd1,
        SEL_DR = 4'd2,
        CAP_DR = 4'd3,
        SH_DR  = 4'd4,
        EX1_DR = 4'd5,
        PAU_DR = 4'd6,
        EX2_DR = 4'd7,
        UPD_DR = 4'd8,
        SEL_IR = 4'd9,
        CAP_IR = 4'd10,
        SH_IR  = 4'd11,
        EX1_IR = 4'd12,
        PAU_IR = 4'd13,
        EX2_IR = 4'd14,
        UPD_IR = 4'd15
    } tap_state_e;

endpackage

// File: rtl/tdt_dtm_tap_fsm.sv
// rtl/tdt_dtm_tap_fsm.sv - 16-state 1149.1 TAP state machine
module tdt_dtm_tap_fsm
    import tdt_dtm_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_b_i,
    input  logic       tap_en_i,
    input  logic       tms_i,
    output logic [3:0] state_o,
    output logic [3:0] state_d_o
);

    tap_state_e state_q, state_d;

    always_ff @(posedge clk_i) begin
        if (!rst_b_i) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!tap_en_i) begin
            state_d = TLR;
        end else begin
            case (state_q)
                TLR:    state_d = tms_i ? TLR    : RTI;
                RTI:    state_d = tms_i ? SEL_DR : RTI;
                SEL_DR: state_d = tms_i ? SEL_IR : CAP_DR;
                CAP_DR: state_d = tms_i ? EX1_DR : SH_DR;
                SH_DR:  state_d = tms_i ? EX1_DR : SH_DR;
                EX1_DR: state_d = tms_i ? UPD_DR : PAU_DR;
                PAU_DR: state_d = tms_i ? EX2_DR : PAU_DR;
                EX2_DR: state_d = tms_i ? UPD_DR : SH_DR;
                UPD_DR: state_d = tms_i ? SEL_DR : RTI;
                SEL_IR: state_d = tms_i ? TLR    : CAP_IR;
                CAP_IR: state_d = tms_i ? EX1_IR : SH_IR;
                SH_IR:  state_d = tms_i ? EX1_IR : SH_IR;
                EX1_IR: state_d = tms_i ? UPD_IR : PAU_IR;
                PAU_IR: state_d = tms_i ? EX2_IR : PAU_IR;
                EX2_IR: state_d = tms_i ? UPD_IR : SH_IR;
                UPD_IR: state_d = tms_i ? SEL_DR : RTI;
                default: state_d = TLR;
            endcase
        end
    end

    assign state_o   = state_q;
    assign state_d_o = state_d;

endmodule

// File: rtl/tdt_dtm_tap_ctrl.sv
// rtl/tdt_dtm_tap_ctrl.sv - JTAG TAP controller with IR, IDCODE/BYPASS DRs and TDO mux
module tdt_dtm_tap_ctrl
    import tdt_dtm_pkg::*;
#(
    parameter int              IR_W       = DTM_IR_W,
    parameter logic [31:0]     IDCODE_VAL = DTM_IDCODE_VAL,
    parameter logic [IR_W-1:0] IR_IDCODE  = DTM_IR_IDCODE,
    parameter logic [IR_W-1:0] IR_DTMCS   = DTM_IR_DTMCS,
    parameter logic [IR_W-1:0] IR_DMI     = DTM_IR_DMI
) (
    input  logic            pad_dtm_tclk,
    input  logic            pad_dtm_trst_b,
    input  logic            io_ctrl_tap_en,
    input  logic            pad_dtm_tms_i,
    input  logic            io_chain_tdi,
    input  logic            ext_dr_tdo,
    output logic            chain_io_tdo,
    output logic            ctrl_io_tdo_en,
    output logic [IR_W-1:0] tap_ir,
    output logic [3:0]      tap_state,
    output logic            tap_capture_dr,
    output logic            tap_shift_dr,
    output logic            tap_update_dr
);

    logic [3:0]      state, state_nx;
    logic [IR_W-1:0] ir_sh_q, ir_sh_d;
    logic [IR_W-1:0] tap_ir_q, tap_ir_d;
    logic [31:0]     idcode_q, idcode_d;
    logic            bypass_q, bypass_d;
    logic            sel_idcode, sel_ext, ext_act;

    tdt_dtm_tap_fsm u_fsm (
        .clk_i     (pad_dtm_tclk),
        .rst_b_i   (pad_dtm_trst_b),
        .tap_en_i  (io_ctrl_tap_en),
        .tms_i     (pad_dtm_tms_i),
        .state_o   (state),
        .state_d_o (state_nx)
    );

    assign sel_idcode = (tap_ir_q == IR_IDCODE);
    assign sel_ext    = (tap_ir_q == IR_DTMCS) || (tap_ir_q == IR_DMI);
    assign ext_act    = io_ctrl_tap_en && sel_ext;

    always_comb begin
        ir_sh_d  = ir_sh_q;
        tap_ir_d = tap_ir_q;
        idcode_d = idcode_q;
        bypass_d = bypass_q;
        if (io_ctrl_tap_en) begin
            case (state)
                CAP_IR: ir_sh_d  = {{(IR_W-2){1'b0}}, 2'b01};
                SH_IR:  ir_sh_d  = {io_chain_tdi, ir_sh_q[IR_W-1:1]};
                UPD_IR: tap_ir_d = ir_sh_q;
                CAP_DR: begin
                    idcode_d = IDCODE_VAL;
                    bypass_d = 1'b0;
                end
                SH_DR: begin
                    if (sel_idcode) begin
                        idcode_d = {io_chain_tdi, idcode_q[31:1]};
                    end else if (!sel_ext) begin
                        bypass_d = io_chain_tdi;
                    end
                end
                default: ;
            endcase
        end
        // Keyed on the next state so tap_ir already reads IDCODE on arrival in TLR.
        if (state_nx == TLR) begin
            tap_ir_d = IR_IDCODE;
        end
    end

    always_ff @(posedge pad_dtm_tclk) begin
        if (!pad_dtm_trst_b) begin
            ir_sh_q  <= '0;
            tap_ir_q <= IR_IDCODE;
            idcode_q <= '0;
            bypass_q <= 1'b0;
        end else begin
            ir_sh_q  <= ir_sh_d;
            tap_ir_q <= tap_ir_d;
            idcode_q <= idcode_d;
            bypass_q <= bypass_d;
        end
    end

    always_comb begin
        chain_io_tdo = 1'b0;
        if (state == SH_IR) begin
            chain_io_tdo = ir_sh_q[0];
        end else if (state == SH_DR) begin
            if (sel_ext) begin
                chain_io_tdo = ext_dr_tdo;
            end else if (sel_idcode) begin
                chain_io_tdo = idcode_q[0];
            end else begin
                chain_io_tdo = bypass_q;
            end
        end
    end

    assign ctrl_io_tdo_en = (state == SH_IR) || (state == SH_DR);
    assign tap_capture_dr = ext_act && (state == CAP_DR);
    assign tap_shift_dr   = ext_act && (state == SH_DR);
    assign tap_update_dr  = ext_act && (state == UPD_DR);
    assign tap_ir         = tap_ir_q;
    assign tap_state      = state;

endmodule

// File: tb/tb_tdt_dtm_tap_ctrl.sv
// tb/tb_tdt_dtm_tap_ctrl.sv - directed scoreboard bench for tdt_dtm_tap_ctrl
module tb_tdt_dtm_tap_ctrl;
    import tdt_dtm_pkg::*;

    logic       clk = 1'b0;
    logic       trst_b, tap_en, tms, tdi, ext_tdo;
    logic       tdo, tdo_en, cap, sh, upd;
    logic [4:0] ir;
    logic [3:0] st;

    int   total = 0;
    int   bad   = 0;
    int   cap_n, sh_n, upd_n;
    logic q[$];

    always #5 clk = ~clk;

    tdt_dtm_tap_ctrl dut (
        .pad_dtm_tclk   (clk),
        .pad_dtm_trst_b (trst_b),
        .io_ctrl_tap_en (tap_en),
        .pad_dtm_tms_i  (tms),
        .io_chain_tdi   (tdi),
        .ext_dr_tdo     (ext_tdo),
        .chain_io_tdo   (tdo),
        .ctrl_io_tdo_en (tdo_en),
        .tap_ir         (ir),
        .tap_state      (st),
        .tap_capture_dr (cap),
        .tap_shift_dr   (sh),
        .tap_update_dr  (upd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic obs);
        logic e;
        e = (q.size() > 0) ? q.pop_front() : 1'bx;
        chk(tag, {31'd0, obs}, {31'd0, e});
    endtask

    task automatic step(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge clk);
        #1;
        if (cap) cap_n++;
        if (sh)  sh_n++;
        if (upd) upd_n++;
    endtask

    task automatic ir_scan(input logic [4:0] val);
        logic [4:0] capv;
        capv = 5'b00001;
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 5; i++) q.push_back(capv[i]);
        for (int i = 0; i < 5; i++) begin
            chk("ir_tdo_en", {31'd0, tdo_en}, 32'd1);
            pop_chk("ir_tdo", tdo);
            step(i == 4, val[i]);
        end
        step(1, 0); step(0, 0);
        chk("ir_after_scan", {27'd0, ir}, {27'd0, val});
    endtask

    initial begin
        logic [31:0] idv;
        logic [2:0]  byp_in, byp_out;
        logic        b;
        idv     = 32'h1000_0B6D;
        byp_in  = 3'b101;
        byp_out = 3'b010;
        cap_n = 0; sh_n = 0; upd_n = 0;
        trst_b = 1'b0; tap_en = 1'b1; tms = 1'b0; tdi = 1'b0; ext_tdo = 1'b0;

        step(0, 0); step(0, 0);
        chk("rst_state", {28'd0, st}, 32'd0);
        chk("rst_ir", {27'd0, ir}, 32'h01);
        chk("rst_tdo_en", {31'd0, tdo_en}, 32'd0);
        chk("rst_tdo", {31'd0, tdo}, 32'd0);
        chk("rst_strobes", {29'd0, cap, sh, upd}, 32'd0);
        trst_b = 1'b1;

        step(0, 0); step(1, 0); step(0, 0); step(0, 0);
        chk("id_in_shdr", {28'd0, st}, 32'd4);
        for (int i = 0; i < 32; i++) q.push_back(idv[i]);
        for (int i = 0; i < 32; i++) begin
            chk("id_tdo_en", {31'd0, tdo_en}, 32'd1);
            pop_chk("id_tdo", tdo);
            step(i == 31, 0);
        end
        chk("id_ex1", {28'd0, st}, 32'd5);
        step(1, 0); step(0, 0);
        chk("id_rti", {28'd0, st}, 32'd1);

        ir_scan(5'h1F);
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 3; i++) q.push_back(byp_out[2-i]);
        for (int i = 0; i < 3; i++) begin
            pop_chk("byp_tdo", tdo);
            step(i == 2, byp_in[2-i]);
        end
        step(1, 0); step(0, 0);
        chk("byp_ir_kept", {27'd0, ir}, 32'h1F);

        step(1, 0); step(0, 0); step(0, 0);
        chk("tlr5_shdr", {28'd0, st}, 32'd4);
        for (int i = 0; i < 5; i++) step(1, 0);
        chk("tlr5_state", {28'd0, st}, 32'd0);
        chk("tlr5_ir", {27'd0, ir}, 32'h01);
        step(0, 0);

        ir_scan(5'h11);
        cap_n = 0; sh_n = 0; upd_n = 0;
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 41; i++) begin
            b = 1'($urandom_range(1, 0));
            ext_tdo = b;
            q.push_back(b);
            #1;
            pop_chk("ext_tdo", tdo);
            step(i == 40, 1'($urandom_range(1, 0)));
        end
        step(1, 0); step(0, 0);
        chk("ext_cap_n", cap_n, 32'd1);
        chk("ext_sh_n", sh_n, 32'd41);
        chk("ext_upd_n", upd_n, 32'd1);
        chk("ext_ir_kept", {27'd0, ir}, 32'h11);

        step(1, 0); step(0, 0); step(0, 0);
        chk("en_shdr", {31'd0, sh}, 32'd1);
        cap_n = 0; sh_n = 0; upd_n = 0;
        tap_en = 1'b0;
        step(0, 0);
        chk("en_state", {28'd0, st}, 32'd0);
        chk("en_tdo_en", {31'd0, tdo_en}, 32'd0);
        chk("en_ir", {27'd0, ir}, 32'h01);
        chk("en_no_upd", upd_n, 32'd0);
        step(1, 0);
        chk("en_no_strobes", cap_n + sh_n + upd_n, 32'd0);
        tap_en = 1'b1;
        step(0, 0);
        chk("en_resume_rti", {28'd0, st}, 32'd1);
        chk("sb_drained", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
